// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl
//   Interval timer sequencer with its own N-bit count register. It takes the
//   count from 0 up to a latched terminal value, with an optional prescaler,
//   in one-shot or periodic mode, and a level hold. A registered one-cycle
//   tick marks each interval end.
// Parameters:
//   N        count/limit width (>= 1)
//   PRESCALE clock cycles per count step (>= 1)
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high clear
//   start    (re)start the timer, latches limit and periodic
//   stop     abort to IDLE (wins over start)
//   hold     freeze count and prescaler while running
//   periodic 1 = auto-reload, 0 = one-shot (latched on start)
//   limit    terminal count (latched on start)
//   count    current count
//   tick     one-cycle pulse on the wrap edge
//   busy     high while running
//   done     high after a one-shot completes
module counter_timer_ctrl #(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         hold,
  input  logic         periodic,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         tick,
  output logic         busy,
  output logic         done
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state_n;
  logic [N-1:0]  r_count, w_count_n;
  logic [N-1:0]  r_limit, w_limit_n;
  logic [PW-1:0] r_pre,   w_pre_n;
  logic          r_mode,  w_mode_n;
  logic          r_tick,  w_tick_n;
  logic          w_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_limit <= '0;
      r_pre   <= '0;
      r_mode  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_limit <= w_limit_n;
      r_pre   <= w_pre_n;
      r_mode  <= w_mode_n;
      r_tick  <= w_tick_n;
    end
  end

  // With PRESCALE == 1 the prescaler is stuck at 0 == PRE_LAST, so every
  // running edge is a step.
  assign w_step = (r_pre == PRE_LAST);

  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_limit_n = r_limit;
    w_pre_n   = r_pre;
    w_mode_n  = r_mode;
    w_tick_n  = 1'b0;
    if (stop) begin
      w_state_n = S_IDLE;
      w_count_n = '0;
      w_pre_n   = '0;
    end else if (start) begin
      // A start while running discards the current interval's progress.
      w_state_n = S_RUN;
      w_limit_n = limit;
      w_mode_n  = periodic;
      w_count_n = '0;
      w_pre_n   = '0;
    end else if (r_state == S_RUN && !hold) begin
      w_pre_n = w_step ? '0 : r_pre + 1'b1;
      if (w_step) begin
        if (r_count == r_limit) begin
          w_count_n = '0;
          w_tick_n  = 1'b1;
          if (!r_mode) w_state_n = S_DONE;
        end else begin
          w_count_n = r_count + 1'b1;
        end
      end
    end
  end

  // All outputs come straight from registers.
  assign count = r_count;
  assign tick  = r_tick;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

endmodule

// File: doc/counter_timer_ctrl.md
# counter_timer_ctrl

Sequencer for the team's N-bit up-counter datapath. It runs the counter as a programmable interval timer with a terminal value, an optional prescaler, one-shot or periodic mode, and a level-sensitive hold. It sits between control logic (buttons or a higher-level FSM) and the counter value it exposes, and produces a single-cycle tick at each interval end. It owns its own count register, so no external counter instance is needed.

## Interface
- N, default 4: count and limit width in bits (N ≥ 1).
- PRESCALE, default 1: clock cycles per count increment (PRESCALE ≥ 1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  sampled each edge; (re)starts the timer.
- stop  input  1  sampled each edge; aborts to IDLE.
- hold  input  1  level; freezes count and prescaler while in RUN.
- periodic  input  1  mode, latched on start: 1 = auto-reload, 0 = one-shot.
- limit  input  N  terminal count, latched on start.
- count  output  N  current count value.
- tick  output  1  registered one-cycle pulse at interval end.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot finished).

## Operation
- Reset: state IDLE; count = 0, prescaler = 0, limit_q = 0, mode_q = 0, tick = 0, busy = 0, done = 0.
- States and outputs:
  - IDLE: counter stopped at 0.
  - RUN: counter advances.
  - DONE: one-shot complete, count held at 0, done = 1.
- Input priority per edge: stop > start > hold.
- stop (any state): go to IDLE; count = 0; prescaler = 0; tick = 0.
- start without stop (IDLE, RUN or DONE): go to RUN; limit_q ← limit; mode_q ← periodic; count = 0; prescaler = 0. A start in RUN restarts the interval and discards progress.
- RUN, hold = 1: count, prescaler and state unchanged; tick = 0.
- RUN, hold = 0: prescaler advances 0..PRESCALE−1 and wraps. A step occurs on the edge where the prescaler equals PRESCALE−1. With PRESCALE = 1, every edge is a step.
- Step with count ≠ limit_q: count ← count + 1.
- Step with count == limit_q (wrap):
  - count ← 0; tick ← 1 for exactly one cycle.
  - mode_q = 1: stay in RUN.
  - mode_q = 0: go to DONE.
- limit_q = 0: every step is a wrap, so tick fires once per PRESCALE cycles.
- Arithmetic is unsigned modulo 2^N. limit = 2^N−1 gives the full natural wrap.
- limit and periodic are ignored except on a start edge; changing them mid-run has no effect.
- tick is 0 on every edge that is not a wrap.

## Timing
- Reset is asynchronous: outputs clear immediately on reset = 1, with no clock required, and stay cleared while reset is high.
- Start sampled at edge k: busy = 1, count = 0 after edge k.
- First increment at edge k + PRESCALE.
- Wrap at edge k + (limit_q+1)·PRESCALE. tick is high from that edge until the next one.
- Periodic interval: (limit_q+1)·PRESCALE cycles between ticks, with no dead cycle.
- Each hold-high edge in RUN extends the interval by one cycle.
- One-shot: done = 1 and busy = 0 from the wrap edge. tick and done rise on the same edge.
- Latency from stop or start to outputs: one edge. count, busy, done and tick are all registered, with no combinational path from inputs.

## Test plan
All scenarios use N = 4, PRESCALE = 1 unless stated.

- Reset asserted with clk held low → count = 0, tick = 0, busy = 0, done = 0 without a clock edge. Reset asserted mid-RUN at count = 5 → immediate return to all zeros and IDLE.
- Periodic, limit = 3, start for one edge → count 1, 2, 3, 0, 1, … on successive edges. tick high only in the cycles where count returns to 0, one pulse every 4 cycles; busy stays 1.
- One-shot, limit = 15 → count reaches 15 after 15 edges; the 16th edge gives count = 0, tick = 1, done = 1, busy = 0. On the next edge, tick = 0 and done stays 1 until the next start.
- Hold high for 3 edges at count = 2 → count stays 2 for those cycles and the tick is delayed by 3 cycles. Then stop and start together at count = 7 → IDLE, count = 0, busy = 0.
- limit = 0, periodic → tick = 1 on every cycle, count stays 0. Restart with start at count = 9 (limit = 12) → count = 0 next edge, and the new limit_q = 12 takes effect.
- N = 6, PRESCALE = 3, periodic, limit = 2 → count changes every 3rd edge (0, 0, 0, 1, 1, 1, 2, 2, 2, 0). tick fires once every 9 cycles.
